// File: rtl/stack_sequencer.sv
// Nibble program sequencer for the stack calculator core.
// Streams a stored program onto cpu_inbits, paced by opcode execute lengths.
module stack_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prog_we,
  input  logic [ADDR_BITS-1:0] prog_addr,
  input  logic [3:0]           prog_data,
  input  logic [ADDR_BITS:0]   prog_len,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 abort,
  output logic                 cpu_rst,
  output logic [3:0]           cpu_inbits,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] pc
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FETCH,
    EXEC,
    FIN
  } state_t;

  localparam logic [ADDR_BITS:0] ONE = 1;
  localparam logic [ADDR_BITS:0] TWO = 2;

  state_t             state;
  logic [3:0]         mem [PROG_DEPTH];
  logic [ADDR_BITS:0] pc_q;
  logic [ADDR_BITS:0] len_q;
  logic [ADDR_BITS:0] pc1;
  logic [ADDR_BITS:0] npc;
  logic [1:0]         cnt;
  logic               opnd;
  logic               abort_seen;
  logic [3:0]         op_nib;
  logic [3:0]         nxt_nib;

  function automatic logic [1:0] exec_len(
    input logic [3:0] op
  );
    case (op)
      4'h1, 4'h6, 4'h7, 4'h8: exec_len = 2'd2;
      4'h2, 4'h5:             exec_len = 2'd2;
      4'h9, 4'hA, 4'hC, 4'hD: exec_len = 2'd3;
      default:                exec_len = 2'd1;
    endcase
  endfunction

  function automatic logic has_opnd(
    input logic [3:0] op
  );
    case (op)
      4'h1, 4'h6, 4'h7, 4'h8: has_opnd = 1'b1;
      default:                has_opnd = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (prog_we && !busy)
      mem[prog_addr] <= prog_data;
  end

  // A truncated operand clamps pc to len so the run ends at len.
  always_comb begin
    pc1 = pc_q + ONE;
    npc = opnd ? pc_q + TWO : pc1;
    if (npc > len_q)
      npc = len_q;
    op_nib = 4'h0;
    if (pc1 < len_q)
      op_nib = mem[pc1[ADDR_BITS-1:0]];
    nxt_nib = mem[npc[ADDR_BITS-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_rst    <= 1'b1;
      cpu_inbits <= 4'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pc_q       <= '0;
      len_q      <= '0;
      cnt        <= 2'd0;
      opnd       <= 1'b0;
      abort_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_rst <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            pc_q       <= '0;
            len_q      <= prog_len;
            abort_seen <= 1'b0;
            busy       <= 1'b1;
            cpu_inbits <= 4'h0;
            if (prog_len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else if (clear) begin
              state   <= CLR;
              cpu_rst <= 1'b1;
            end else begin
              state      <= FETCH;
              cpu_inbits <= mem[0];
            end
          end
        end
        CLR: begin
          abort_seen <= abort_seen | abort;
          cpu_rst    <= 1'b0;
          cpu_inbits <= mem[pc_q[ADDR_BITS-1:0]];
          state      <= FETCH;
        end
        FETCH: begin
          abort_seen <= abort_seen | abort;
          opnd       <= has_opnd(cpu_inbits);
          cnt        <= exec_len(cpu_inbits);
          cpu_inbits <= has_opnd(cpu_inbits) ? op_nib : 4'h0;
          state      <= EXEC;
        end
        EXEC: begin
          abort_seen <= abort_seen | abort;
          if (cnt == 2'd1) begin
            pc_q <= npc;
            if (abort_seen || abort || npc >= len_q) begin
              state      <= FIN;
              done       <= 1'b1;
              cpu_inbits <= 4'h0;
            end else begin
              state      <= FETCH;
              cpu_inbits <= nxt_nib;
              abort_seen <= 1'b0;
            end
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign pc = pc_q[ADDR_BITS-1:0];

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer.
// Outputs are packed as {cpu_rst, cpu_inbits, busy, done, pc}.
module tb_stack_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [3:0] prog_data;
  logic [4:0] prog_len;
  logic       start;
  logic       clear;
  logic       abort;
  logic       cpu_rst;
  logic [3:0] cpu_inbits;
  logic       busy;
  logic       done;
  logic [3:0] pc;

  int applied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  stack_sequencer #(
    .PROG_DEPTH(16),
    .ADDR_BITS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .start     (start),
    .clear     (clear),
    .abort     (abort),
    .cpu_rst   (cpu_rst),
    .cpu_inbits(cpu_inbits),
    .busy      (busy),
    .done      (done),
    .pc        (pc)
  );

  typedef struct {
    logic        start;
    logic        clear;
    logic [4:0]  len;
    logic        we;
    logic [3:0]  addr;
    logic [3:0]  data;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [10:0] e(
    input int r, input int i, input int b,
    input int d, input int p
  );
    return {1'(r), 4'(i), 1'(b), 1'(d), 4'(p)};
  endfunction

  function automatic vec_t v(
    input int s, input int c, input int l,
    input int w, input int a, input int dt,
    input logic [10:0] ex
  );
    vec_t t;
    t.start = 1'(s);
    t.clear = 1'(c);
    t.len   = 5'(l);
    t.we    = 1'(w);
    t.addr  = 4'(a);
    t.data  = 4'(dt);
    t.exp   = ex;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [10:0] ex);
    logic [10:0] act;
    act = {cpu_rst, cpu_inbits, busy, done, pc};
    applied++;
    if (act !== ex) begin
      miscompares++;
      $display("FAIL %s: rst/inb/busy/done/pc got %b_%h_%b_%b_%h required %b_%h_%b_%b_%h",
               name, act[10], act[9:6], act[5], act[4], act[3:0],
               ex[10], ex[9:6], ex[5], ex[4], ex[3:0]);
    end
  endtask

  task automatic idle_inputs();
    prog_we = 1'b0;
    start   = 1'b0;
    clear   = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic load(input logic [3:0] p[$]);
    foreach (p[k]) begin
      prog_we   = 1'b1;
      prog_addr = 4'(k);
      prog_data = p[k];
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic go(input int l, input logic c);
    prog_len = 5'(l);
    clear    = c;
    start    = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    logic [3:0] inb2[12] = '{1, 3, 3, 1, 4, 4, 9, 0, 0, 0, 4, 0};
    logic [3:0] pc2[12]  = '{0, 0, 0, 2, 2, 2, 4, 4, 4, 4, 5, 5};

    tbl[0]  = v(1, 1, 3, 0, 0, 0,  e(1, 0, 1, 0, 0));
    tbl[1]  = v(0, 0, 0, 0, 0, 0,  e(0, 1, 1, 0, 0));
    tbl[2]  = v(1, 0, 3, 0, 0, 0,  e(0, 5, 1, 0, 0));
    tbl[3]  = v(0, 0, 0, 1, 1, 15, e(0, 5, 1, 0, 0));
    tbl[4]  = v(0, 0, 0, 0, 0, 0,  e(0, 3, 1, 0, 2));
    tbl[5]  = v(0, 0, 0, 0, 0, 0,  e(0, 0, 1, 0, 2));
    tbl[6]  = v(0, 0, 0, 0, 0, 0,  e(0, 0, 1, 1, 3));
    tbl[7]  = v(0, 0, 0, 0, 0, 0,  e(0, 0, 0, 0, 3));
    tbl[8]  = v(1, 0, 3, 0, 0, 0,  e(0, 1, 1, 0, 0));
    tbl[9]  = v(0, 0, 0, 0, 0, 0,  e(0, 5, 1, 0, 0));
    tbl[10] = v(0, 0, 0, 0, 0, 0,  e(0, 5, 1, 0, 0));
    tbl[11] = v(0, 0, 0, 0, 0, 0,  e(0, 3, 1, 0, 2));
    tbl[12] = v(0, 0, 0, 0, 0, 0,  e(0, 0, 1, 0, 2));
    tbl[13] = v(0, 0, 0, 0, 0, 0,  e(0, 0, 1, 1, 3));
    tbl[14] = v(0, 0, 0, 0, 0, 0,  e(0, 0, 0, 0, 3));
    tbl[15] = v(1, 1, 0, 0, 0, 0,  e(0, 0, 1, 1, 0));
    tbl[16] = v(0, 0, 0, 0, 0, 0,  e(0, 0, 0, 0, 0));

    idle_inputs();
    prog_addr = 4'h0;
    prog_data = 4'h0;
    prog_len  = 5'd0;
    rst = 1'b1;
    tick();
    chk("reset", e(1, 0, 0, 0, 0));
    rst = 1'b0;
    tick();
    chk("post_reset", e(0, 0, 0, 0, 0));

    // [1,5,3] with clear, busy-time start/write, rerun, len=0
    load('{4'h1, 4'h5, 4'h3});
    for (int i = 0; i < 17; i++) begin
      start     = tbl[i].start;
      clear     = tbl[i].clear;
      prog_len  = tbl[i].len;
      prog_we   = tbl[i].we;
      prog_addr = tbl[i].addr;
      prog_data = tbl[i].data;
      tick();
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    idle_inputs();

    // [1,3,1,4,9,4] without clear: 12 busy cycles
    load('{4'h1, 4'h3, 4'h1, 4'h4, 4'h9, 4'h4});
    go(6, 1'b0);
    chk("mult_c0", e(0, inb2[0], 1, 0, pc2[0]));
    for (int i = 1; i < 12; i++) begin
      tick();
      chk($sformatf("mult_c%0d", i),
          e(0, inb2[i], 1, 0, pc2[i]));
    end
    tick();
    chk("mult_fin", e(0, 0, 1, 1, 6));
    tick();
    chk("mult_idle", e(0, 0, 0, 0, 6));

    // truncated PUSH: mem[1] still holds 3 but operand must be 0
    load('{4'h1});
    go(1, 1'b0);
    chk("trunc_fetch", e(0, 1, 1, 0, 0));
    tick();
    chk("trunc_ex1", e(0, 0, 1, 0, 0));
    tick();
    chk("trunc_ex2", e(0, 0, 1, 0, 0));
    tick();
    chk("trunc_fin", e(0, 0, 1, 1, 1));
    tick();
    chk("trunc_idle", e(0, 0, 0, 0, 1));

    // abort during first EXEC of [2,2,2]
    load('{4'h2, 4'h2, 4'h2});
    go(3, 1'b0);
    chk("abort_fetch", e(0, 2, 1, 0, 0));
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ex2", e(0, 0, 1, 0, 0));
    tick();
    chk("abort_fin", e(0, 0, 1, 1, 1));
    tick();
    chk("abort_idle", e(0, 0, 0, 0, 1));

    // abort during CLR waits for the first instruction
    go(3, 1'b1);
    chk("aclr_clr", e(1, 0, 1, 0, 0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("aclr_fetch", e(0, 2, 1, 0, 0));
    tick();
    tick();
    chk("aclr_ex2", e(0, 0, 1, 0, 0));
    tick();
    chk("aclr_fin", e(0, 0, 1, 1, 1));
    tick();

    // rst mid-EXEC
    go(3, 1'b0);
    tick();
    chk("rst_ex1", e(0, 0, 1, 0, 0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hit", e(1, 0, 0, 0, 0));
    tick();
    chk("rst_after", e(0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule
